// File: rtl/axis_upsize_packer.sv
// rtl/axis_upsize_packer.sv - AXI4-Stream upsizer packing RATIO narrow beats into one wide beat.
// Early flush on tlast; unfilled lanes of a flushed word carry zero data and zero keep.
module axis_upsize_packer #(
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 4,
  parameter int USER_WIDTH   = 1,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  parameter int M_DATA_WIDTH = S_DATA_WIDTH * RATIO,
  parameter int M_KEEP_WIDTH = S_KEEP_WIDTH * RATIO
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [LANE_W-1:0]       lane;
  logic [M_DATA_WIDTH-1:0] acc_data;
  logic [M_KEEP_WIDTH-1:0] acc_keep;
  logic [USER_WIDTH-1:0]   acc_user;

  logic                    in_fire;
  logic                    final_beat;
  logic [M_DATA_WIDTH-1:0] word_data;
  logic [M_KEEP_WIDTH-1:0] word_keep;
  logic [USER_WIDTH-1:0]   word_user;

  // Input stalls whenever an output word is held, even for non-final lanes.
  assign s_axis_tready = rstn && (!m_axis_tvalid || m_axis_tready);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign final_beat    = (lane == LANE_W'(RATIO - 1)) || s_axis_tlast;
  assign word_user     = (lane == '0) ? s_axis_tuser : acc_user;

  // Accumulated lanes with the current beat merged into lane `lane`.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == LANE_W'(i)) begin
        word_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
        word_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_axis_tkeep;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lane          <= '0;
      acc_data      <= '0;
      acc_keep      <= '0;
      acc_user      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (in_fire) begin
        if (final_beat) begin
          // A final beat in the same cycle as an output handshake overrides the clear above.
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= word_data;
          m_axis_tkeep  <= word_keep;
          m_axis_tlast  <= s_axis_tlast;
          m_axis_tuser  <= word_user;
          lane          <= '0;
          acc_data      <= '0;
          acc_keep      <= '0;
        end else begin
          acc_data <= word_data;
          acc_keep <= word_keep;
          if (lane == '0) begin
            acc_user <= s_axis_tuser;
          end
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_upsize_packer.sv
// tb/tb_axis_upsize_packer.sv - directed self-checking bench for axis_upsize_packer (8-bit x 4).
module tb_axis_upsize_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  s_tdata;
  logic [0:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [0:0]  m_tuser;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_upsize_packer #(
    .S_DATA_WIDTH(8),
    .RATIO(4),
    .USER_WIDTH(1)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat, check it is accepted, advance past the edge.
  task automatic send(input logic [7:0] d, input logic k, input logic l, input logic u);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    #1;
    chk("s_ready", s_tready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l, input logic u);
    chk({tag, ".valid"}, m_tvalid, 1);
    chk({tag, ".data"}, m_tdata, d);
    chk({tag, ".keep"}, m_tkeep, k);
    chk({tag, ".last"}, m_tlast, l);
    chk({tag, ".user"}, m_tuser, u);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, m_tvalid, 0);
    chk({tag, ".data"}, m_tdata, 0);
    chk({tag, ".keep"}, m_tkeep, 0);
    chk({tag, ".last"}, m_tlast, 0);
    chk({tag, ".user"}, m_tuser, 0);
    chk({tag, ".s_ready"}, s_tready, 0);
  endtask

  initial begin
    rstn = 1'b0; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tuser = '0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full words 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b1, (i == 8), 1'b0);
      if (i == 3) chk("full.lat_valid", m_tvalid, 0);
      if (i == 4) chk_word("full.w0", 32'h04030201, 4'hF, 1'b0, 1'b0);
      if (i == 5) chk("full.drop_valid", m_tvalid, 0);
      if (i == 8) chk_word("full.w1", 32'h08070605, 4'hF, 1'b1, 1'b0);
    end

    // Partial flush, then lane-0 restart and single-beat packets
    send(8'hA1, 1'b1, 1'b0, 1'b0);
    chk("part.drop_valid", m_tvalid, 0);
    send(8'hA2, 1'b1, 1'b0, 1'b0);
    send(8'hA3, 1'b1, 1'b1, 1'b0);
    chk_word("part", 32'h00A3A2A1, 4'h7, 1'b1, 1'b0);
    send(8'hB1, 1'b1, 1'b1, 1'b0);
    chk_word("lane0", 32'h000000B1, 4'h1, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b1, 1'b0);
    chk_word("single", 32'h00000055, 4'h1, 1'b1, 1'b0);

    // Backpressure while 0x11 is offered
    m_tready = 1'b0;
    s_tdata = 8'h11; s_tkeep = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.s_ready", s_tready, 0);
      @(posedge clk);
      #1;
      chk("bp.hold_data", m_tdata, 32'h00000055);
      chk("bp.hold_valid", m_tvalid, 1);
    end
    m_tready = 1'b1;
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h12, 1'b1, 1'b0, 1'b0);
    send(8'h13, 1'b1, 1'b0, 1'b0);
    send(8'h14, 1'b1, 1'b0, 1'b0);
    chk_word("bp.word", 32'h14131211, 4'hF, 1'b0, 1'b0);

    // tuser on first beat only
    send(8'h31, 1'b1, 1'b0, 1'b1);
    send(8'h32, 1'b1, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0, 1'b0);
    send(8'h34, 1'b1, 1'b1, 1'b0);
    chk_word("user1", 32'h34333231, 4'hF, 1'b1, 1'b1);

    // tuser on second beat only, keep=0 on third beat
    send(8'h21, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b1);
    send(8'h23, 1'b0, 1'b0, 1'b0);
    send(8'h24, 1'b1, 1'b1, 1'b0);
    chk_word("user2", 32'h24232221, 4'hB, 1'b1, 1'b0);

    // Reset mid-word discards partial lanes
    send(8'hC1, 1'b1, 1'b0, 1'b0);
    send(8'hC2, 1'b1, 1'b0, 1'b0);
    s_tvalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("midrst");
    rstn = 1'b1;
    send(8'hD1, 1'b1, 1'b0, 1'b0);
    chk("midrst.no_c", m_tvalid, 0);
    send(8'hD2, 1'b1, 1'b0, 1'b0);
    send(8'hD3, 1'b1, 1'b0, 1'b0);
    send(8'hD4, 1'b1, 1'b0, 1'b0);
    chk_word("midrst.word", 32'hD4D3D2D1, 4'hF, 1'b0, 1'b0);

    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain.valid", m_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
